// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one CPU request into the RAM's setup/strobe/hold enable protocol
module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SPACE = 9
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ADDR_SPACE-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_SPACE-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_datain,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_enable,
    input  logic [DATA_WIDTH-1:0] mem_dataout
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
    state_t                  state_q, state_d;
    logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                    mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic                    mem_enable_q, mem_enable_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d, mem_datain_q, mem_datain_d;
    logic [ADDR_SPACE-1:0]   mem_addr_q, mem_addr_d;
    logic                    legal, illegal;
    assign legal   = req_read ^ req_write;
    assign illegal = req_read & req_write;
    // next state and registered outputs; IDLE and DONE both accept, the other states ignore req_*
    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        mem_enable_d = 1'b0;
        rdata_d      = rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_datain_d = mem_datain_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = legal ? SETUP : IDLE;
                err_d   = illegal;
                if (legal) begin
                    mem_addr_d   = req_addr;
                    mem_datain_d = req_write ? req_wdata : mem_datain_q;
                    mem_read_d   = req_read;
                    mem_write_d  = req_write;
                end
            end
            SETUP: begin
                state_d      = STROBE;
                mem_enable_d = 1'b1;
            end
            STROBE: state_d = HOLD;
            HOLD: begin
                state_d     = DONE;
                done_d      = 1'b1;
                rdata_d     = mem_read_q ? mem_dataout : rdata_q;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    end
    // state and output registers; clr clears everything without waiting for a clock
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_datain_q <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            mem_enable_q <= mem_enable_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            rdata_q      <= rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_datain_q <= mem_datain_d;
        end
    end
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_datain = mem_datain_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_enable = mem_enable_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench with a RAM model and a word-level reference memory
module tb_mem_access_ctrl;
    logic        clk = 1'b0, clr = 1'b1;
    logic        req_read = 1'b0, req_write = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        busy, done, err, mem_read, mem_write, mem_enable;
    logic [31:0] rdata, mem_datain, mem_dataout = '0;
    logic [8:0]  mem_addr;

    mem_access_ctrl #(.DATA_WIDTH(32), .ADDR_SPACE(9)) dut (
        .clk(clk), .clr(clr), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
        .err(err), .rdata(rdata), .mem_addr(mem_addr), .mem_datain(mem_datain),
        .mem_read(mem_read), .mem_write(mem_write), .mem_enable(mem_enable),
        .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        bit          is_rd;
        bit          is_wr;
        logic [8:0]  addr;
        logic [31:0] din;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ram [512];
    logic [31:0] ref_mem [512];
    logic [31:0] rdata_m = '0, din_m = '0;
    int          cyc = 0, checks = 0, failures = 0, en_cnt = 0;

    // RAM acts on the rising edge of its enable
    always @(posedge mem_enable) begin
        if (mem_write) ram[mem_addr] <= mem_datain;
        if (mem_read) mem_dataout <= ram[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: checks bus contents during each strobe and pops one expectation per done/err
    always @(negedge clk) begin
        exp_t e;
        if (clr) en_cnt = 0;
        else begin
            if (mem_enable) begin
                en_cnt++;
                if (sb.size() != 0) begin
                    e = sb[0];
                    chk("strobe_bus", {busy, mem_addr, mem_read, mem_write, mem_datain},
                        {1'b1, e.addr, e.is_rd, e.is_wr, e.din});
                end
            end
            if (done || err) begin
                if (sb.size() == 0) chk("unexpected_done_err", {done, err}, 2'b00);
                else begin
                    e = sb.pop_front();
                    chk("done_err_busy", {done, err, busy}, {~e.is_err, e.is_err, 1'b0});
                    chk("latency", cyc, e.cyc);
                    chk("rdata", rdata, e.rd);
                    chk("enable_pulses", en_cnt, e.is_err ? 0 : 1);
                end
                en_cnt = 0;
            end
        end
    end

    // present one request at a negedge while the DUT can accept; return at the negedge showing done/err
    task automatic issue(input bit rd, input bit wr, input logic [8:0] addr, input logic [31:0] wd);
        exp_t e;
        bit   seen = 0;
        req_read = rd; req_write = wr; req_addr = addr; req_wdata = wd;
        e.is_err = rd & wr; e.is_rd = rd; e.is_wr = wr; e.addr = addr;
        if (rd & wr) e.cyc = cyc + 1;
        else begin
            if (wr) begin din_m = wd; ref_mem[addr] = wd; end
            if (rd) rdata_m = ref_mem[addr];
            e.cyc = cyc + 4;
        end
        e.din = din_m; e.rd = rdata_m;
        sb.push_back(e);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (done || err) seen = 1;
            else if (!(rd & wr)) begin
                req_read = 1'($urandom); req_write = 1'($urandom);
                req_addr = 9'h1FF ^ 9'($urandom_range(0, 1)); req_wdata = $urandom;
            end
        end
        if (!seen) chk("timeout_done_err", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        req_read = 0; req_write = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {busy, done, err, mem_read, mem_write, mem_enable, mem_addr, mem_datain, rdata}, '0);
    endtask

    // abort a write of 0x12345678 to 0x030 after the given number of edges past acceptance
    task automatic aborted_write(input int edges, input bit lands);
        logic [31:0] old = ram[9'h030];
        req_read = 0; req_write = 1; req_addr = 9'h030; req_wdata = 32'h12345678;
        repeat (edges) @(posedge clk);
        #2 clr = 1;
        #1 check_reset_outputs("reset_async_outputs");
        req_write = 0;
        chk("ram_after_abort", ram[9'h030], lands ? 32'h12345678 : old);
        if (lands) ref_mem[9'h030] = 32'h12345678;
        rdata_m = '0; din_m = '0;
        @(negedge clk); @(negedge clk);
        clr = 0;
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin ram[i] = $urandom; ref_mem[i] = ram[i]; end
        #1 check_reset_outputs("reset_initial");
        @(negedge clk); @(negedge clk);
        clr = 0;
        idle(2);
        chk("idle_after_reset", {busy, mem_enable}, 2'b00);
        issue(0, 1, 9'h010, 32'hDEADBEEF);
        idle(1);
        issue(1, 0, 9'h010, 32'h0);
        idle(1);
        issue(1, 0, 9'h001, 32'h0);
        issue(1, 0, 9'h002, 32'h0);
        issue(1, 0, 9'h003, 32'h0);
        idle(1);
        issue(1, 1, 9'h020, 32'hCAFEF00D);
        idle(1);
        issue(1, 0, 9'h020, 32'h0);
        for (int t = 0; t < 80; t++) begin
            int op = $urandom_range(0, 7);
            logic [8:0] a = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15));
            if (op == 0) issue(1, 1, a, $urandom);
            else if (op <= 3) issue(0, 1, a, $urandom);
            else if (op <= 6) issue(1, 0, a, 32'h0);
            else idle($urandom_range(1, 4));
        end
        idle(2);
        aborted_write(1, 0);
        aborted_write(3, 1);
        chk("no_activity_after_reset", {busy, done, mem_enable}, 3'b000);
        issue(1, 0, 9'h030, 32'h0);
        idle(5);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
